module_reg_datos_arb: RTL and testbench
=======================================

MODULE_REG_DATOS_ARB -- requirements
Module: module_reg_datos_arb

Interface
REQ-001 Parameter DATA_W, default 8, width of one stored word.
REQ-002 Parameter DEPTH, default 1024, number of stored words; power of two, at least 4.
REQ-003 Parameter ADDR_W, default $clog2(DEPTH), address width.
REQ-004 Parameter OUT_W, default 32, width of data_o; OUT_W >= DATA_W.
REQ-005 clk_i  in  1  single clock; all logic on rising edge.
REQ-006 rst_i  in  1  reset, synchronous, active-high.
REQ-007 hold_ctrl_i  in  1  ownership request: 0 = port A (processor), 1 = port B (SPI engine).
REQ-008 addr_a_i  in  ADDR_W  port A word address.
REQ-009 data_a_i  in  DATA_W  port A write data.
REQ-010 wr_a_i / rd_a_i  in  1 each  port A write / read request, one access per cycle.
REQ-011 addr_b_i  in  ADDR_W  port B pointer load value.
REQ-012 ld_ptr_b_i  in  1  load port B pointer from addr_b_i.
REQ-013 data_b_i  in  DATA_W  port B write data.
REQ-014 wr_b_i / rd_b_i  in  1 each  port B write / read request at the current pointer.
REQ-015 data_o  out  OUT_W  last read word, zero-extended.
REQ-016 valid_o  out  1  one-cycle pulse: data_o updated.
REQ-017 src_o  out  1  port that issued the read shown on data_o (0 = A, 1 = B).
REQ-018 owner_o / busy_o  out  1 each  current owner; turnaround in progress.
REQ-019 deny_a_o / deny_b_o  out  1 each  one-cycle pulse: request from that port dropped.
REQ-020 ptr_b_o  out  ADDR_W  port B pointer.
REQ-021 cnt_b_o  out  ADDR_W+1  accepted port B writes since the last pointer load.
REQ-022 ovf_o  out  1  sticky: port B wrote more than DEPTH words since the last pointer load.

Function
REQ-023 The memory SHALL be DEPTH x DATA_W with one access per cycle; writes commit at the clock edge.
REQ-024 The FSM SHALL have states OWN_A, TURN_AB, OWN_B and TURN_BA.
REQ-025 OWN_A with hold_ctrl_i=1 SHALL go to TURN_AB; OWN_B with hold_ctrl_i=0 SHALL go to TURN_BA; in every other case the OWN states hold.
REQ-026 TURN_AB SHALL go to OWN_B and TURN_BA SHALL go to OWN_A unconditionally after one cycle, regardless of hold_ctrl_i.
REQ-027 busy_o SHALL be 1 in TURN states; owner_o SHALL be 1 in OWN_B and TURN_AB, and 0 otherwise.
REQ-028 Only the port that owns the memory in the current state SHALL access it; requests in a TURN state or from the non-owner are dropped, and the matching deny_x_o SHALL pulse the next cycle.
REQ-029 The owner's request SHALL be served in the cycle in which hold_ctrl_i changes, because the state is still an OWN state.
REQ-030 If wr and rd from the same port are both asserted, the write SHALL be performed and the read SHALL be dropped with no deny and no valid.
REQ-031 Read latency SHALL be 1: valid_o pulses the cycle after an accepted read; data_o and src_o hold their value until the next accepted read.
REQ-032 Port B SHALL access memory at ptr_b_o; each accepted wr_b_i or rd_b_i SHALL increment ptr_b_o modulo DEPTH, wrapping DEPTH-1 to 0.
REQ-033 ld_ptr_b_i SHALL be accepted in any state: ptr_b_o <= addr_b_i, cnt_b_o <= 0, ovf_o <= 0; any wr_b_i or rd_b_i in the same cycle is dropped with no deny.
REQ-034 cnt_b_o SHALL increment on each accepted port B write and saturate at DEPTH.
REQ-035 An accepted port B write while cnt_b_o = DEPTH SHALL set ovf_o; the write is still performed and overwrites wrapped data.
REQ-036 Port A SHALL use addr_a_i directly and SHALL NOT affect ptr_b_o, cnt_b_o or ovf_o.

Reset
REQ-037 When rst_i=1 at a clock edge: state OWN_A, data_o=0, valid_o=0, src_o=0, deny_a_o=0, deny_b_o=0, ptr_b_o=0, cnt_b_o=0, ovf_o=0.
REQ-038 Reset SHALL take priority over all requests, including requests in mid-turnaround.
REQ-039 Reset SHALL NOT clear memory contents.
REQ-040 If hold_ctrl_i=1 after reset, the block SHALL go to TURN_AB on the first cycle after reset.

Verification
REQ-041 Port A: write 0xA5 to address 3, then read address 3 -> valid_o one cycle later, data_o=0x000000A5, src_o=0.
REQ-042 Ownership switch: hold 0->1 while wr_a_i is asserted -> A's write is done, busy_o=1 for one cycle, then owner_o=1; wr_a_i two cycles later -> deny_a_o pulse and memory is unchanged.
REQ-043 Pointer wrap: load ptr to DEPTH-2, then three B writes of 0x11, 0x22, 0x33 -> written to DEPTH-2, DEPTH-1 and 0; ptr_b_o=1; cnt_b_o=3.
REQ-044 Overflow: DEPTH+1 B writes after a pointer load -> cnt_b_o=DEPTH, ovf_o=1; a new ld_ptr_b_i clears both.
REQ-045 Collisions: wr and rd together on port A -> write done, no valid_o; ld_ptr_b_i together with wr_b_i -> pointer loaded, no write.
REQ-046 Reset during TURN_AB -> next state OWN_A with all outputs at reset values; memory data written before reset reads back unchanged.

Source files
------------

// File: rtl/module_reg_datos_arb.sv
// rtl/module_reg_datos_arb.sv - dual-owner word memory with hand-over FSM and port B pointer
//
// Purpose: a DEPTH x DATA_W memory that is shared by a processor port (A) and
// an SPI engine port (B). Only one port owns the memory at a time. A one-cycle
// turnaround state separates the two owners.
//
// Ports:
//   clk_i, rst_i            clock, synchronous active-high reset
//   hold_ctrl_i             requested owner (0 = A, 1 = B)
//   addr_a_i, data_a_i      port A address / write data
//   wr_a_i, rd_a_i          port A write / read request
//   addr_b_i, ld_ptr_b_i    port B pointer load value / load strobe
//   data_b_i, wr_b_i, rd_b_i port B write data / write / read at pointer
//   data_o, valid_o, src_o  last read word (zero-extended), update pulse, issuing port
//   owner_o, busy_o         current owner, turnaround in progress
//   deny_a_o, deny_b_o      dropped-request pulses
//   ptr_b_o, cnt_b_o, ovf_o port B pointer, write count since load, sticky overflow
module module_reg_datos_arb #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = $clog2(DEPTH),
  parameter int OUT_W  = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              hold_ctrl_i,
  input  logic [ADDR_W-1:0] addr_a_i,
  input  logic [DATA_W-1:0] data_a_i,
  input  logic              wr_a_i,
  input  logic              rd_a_i,
  input  logic [ADDR_W-1:0] addr_b_i,
  input  logic              ld_ptr_b_i,
  input  logic [DATA_W-1:0] data_b_i,
  input  logic              wr_b_i,
  input  logic              rd_b_i,
  output logic [OUT_W-1:0]  data_o,
  output logic              valid_o,
  output logic              src_o,
  output logic              owner_o,
  output logic              busy_o,
  output logic              deny_a_o,
  output logic              deny_b_o,
  output logic [ADDR_W-1:0] ptr_b_o,
  output logic [ADDR_W:0]   cnt_b_o,
  output logic              ovf_o
);

  typedef enum logic [1:0] {
    OWN_A   = 2'd0,
    TURN_AB = 2'd1,
    OWN_B   = 2'd2,
    TURN_BA = 2'd3
  } state_t;

  localparam logic [ADDR_W:0] CNT_MAX = (ADDR_W + 1)'(DEPTH);

  state_t            state_q;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [OUT_W-1:0]  data_q;
  logic              valid_q, src_q, owner_q, busy_q, deny_a_q, deny_b_q, ovf_q;
  logic [ADDR_W-1:0] ptr_b_q;
  logic [ADDR_W:0]   cnt_b_q;

  logic              own_a, own_b;
  logic              acc_wr_a, acc_rd_a, acc_wr_b, acc_rd_b;
  logic              deny_a_d, deny_b_d;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr, rd_addr;
  logic [DATA_W-1:0] wr_data;

  always_comb begin
    own_a    = (state_q == OWN_A);
    own_b    = (state_q == OWN_B);
    // A write shadows a simultaneous read from the same port.
    acc_wr_a = own_a & wr_a_i;
    acc_rd_a = own_a & rd_a_i & ~wr_a_i;
    // A pointer load swallows any same-cycle port B access without a deny.
    acc_wr_b = own_b & ~ld_ptr_b_i & wr_b_i;
    acc_rd_b = own_b & ~ld_ptr_b_i & rd_b_i & ~wr_b_i;
    deny_a_d = (wr_a_i | rd_a_i) & ~own_a;
    deny_b_d = ~ld_ptr_b_i & (wr_b_i | rd_b_i) & ~own_b;
    wr_en    = ~rst_i & (acc_wr_a | acc_wr_b);
    wr_addr  = acc_wr_b ? ptr_b_q  : addr_a_i;
    wr_data  = acc_wr_b ? data_b_i : data_a_i;
    rd_addr  = acc_rd_b ? ptr_b_q  : addr_a_i;
  end

  // Memory has no reset so its contents survive rst_i.
  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= OWN_A;
      owner_q  <= 1'b0;
      busy_q   <= 1'b0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      src_q    <= 1'b0;
      deny_a_q <= 1'b0;
      deny_b_q <= 1'b0;
      ptr_b_q  <= '0;
      cnt_b_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      // owner/busy are registered together with the state they decode.
      case (state_q)
        OWN_A: if (hold_ctrl_i) begin
          state_q <= TURN_AB;
          owner_q <= 1'b1;
          busy_q  <= 1'b1;
        end
        TURN_AB: begin
          state_q <= OWN_B;
          owner_q <= 1'b1;
          busy_q  <= 1'b0;
        end
        OWN_B: if (!hold_ctrl_i) begin
          state_q <= TURN_BA;
          owner_q <= 1'b0;
          busy_q  <= 1'b1;
        end
        default: begin
          state_q <= OWN_A;
          owner_q <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase

      valid_q  <= acc_rd_a | acc_rd_b;
      deny_a_q <= deny_a_d;
      deny_b_q <= deny_b_d;
      if (acc_rd_a | acc_rd_b) begin
        data_q <= OUT_W'(mem_q[rd_addr]);
        src_q  <= acc_rd_b;
      end

      if (ld_ptr_b_i) begin
        ptr_b_q <= addr_b_i;
        cnt_b_q <= '0;
        ovf_q   <= 1'b0;
      end else begin
        // DEPTH is a power of two, so the natural ADDR_W wrap is modulo DEPTH.
        if (acc_wr_b | acc_rd_b) begin
          ptr_b_q <= ptr_b_q + ADDR_W'(1);
        end
        if (acc_wr_b) begin
          if (cnt_b_q == CNT_MAX) begin
            ovf_q <= 1'b1;
          end else begin
            cnt_b_q <= cnt_b_q + (ADDR_W + 1)'(1);
          end
        end
      end
    end
  end

  assign data_o   = data_q;
  assign valid_o  = valid_q;
  assign src_o    = src_q;
  assign owner_o  = owner_q;
  assign busy_o   = busy_q;
  assign deny_a_o = deny_a_q;
  assign deny_b_o = deny_b_q;
  assign ptr_b_o  = ptr_b_q;
  assign cnt_b_o  = cnt_b_q;
  assign ovf_o    = ovf_q;

endmodule

// File: tb/tb_module_reg_datos_arb.sv
// tb/tb_module_reg_datos_arb.sv - self-checking bench for module_reg_datos_arb
module tb_module_reg_datos_arb;
  localparam int DW = 8;
  localparam int DEPTH = 16;
  localparam int AW = 4;
  localparam int OW = 32;

  logic          clk = 1'b0;
  logic          rst_i = 1'b1;
  logic          hold_ctrl_i = 1'b0;
  logic [AW-1:0] addr_a_i = '0;
  logic [DW-1:0] data_a_i = '0;
  logic          wr_a_i = 1'b0, rd_a_i = 1'b0;
  logic [AW-1:0] addr_b_i = '0;
  logic          ld_ptr_b_i = 1'b0;
  logic [DW-1:0] data_b_i = '0;
  logic          wr_b_i = 1'b0, rd_b_i = 1'b0;
  logic [OW-1:0] data_o;
  logic          valid_o, src_o, owner_o, busy_o, deny_a_o, deny_b_o, ovf_o;
  logic [AW-1:0] ptr_b_o;
  logic [AW:0]   cnt_b_o;

  int vectors = 0;
  int miscompares = 0;

  module_reg_datos_arb #(.DATA_W(DW), .DEPTH(DEPTH), .ADDR_W(AW), .OUT_W(OW)) dut (
    .clk_i(clk), .rst_i(rst_i), .hold_ctrl_i(hold_ctrl_i),
    .addr_a_i(addr_a_i), .data_a_i(data_a_i), .wr_a_i(wr_a_i), .rd_a_i(rd_a_i),
    .addr_b_i(addr_b_i), .ld_ptr_b_i(ld_ptr_b_i), .data_b_i(data_b_i),
    .wr_b_i(wr_b_i), .rd_b_i(rd_b_i),
    .data_o(data_o), .valid_o(valid_o), .src_o(src_o), .owner_o(owner_o),
    .busy_o(busy_o), .deny_a_o(deny_a_o), .deny_b_o(deny_b_o),
    .ptr_b_o(ptr_b_o), .cnt_b_o(cnt_b_o), .ovf_o(ovf_o)
  );

  always #5 clk = ~clk;

  // Behavioural model: owner plus a "turning" flag, plain arrays and ints.
  bit       m_live = 0;
  int       m_owner, m_busy, m_ptr, m_cnt;
  bit       m_valid, m_src, m_da, m_db, m_ovf;
  int       m_data;
  int       m_mem [DEPTH];

  task automatic model_step();
    bit a_ok, b_ok;
    if (rst_i) begin
      m_live = 1; m_owner = 0; m_busy = 0; m_data = 0; m_valid = 0; m_src = 0;
      m_da = 0; m_db = 0; m_ptr = 0; m_cnt = 0; m_ovf = 0;
      return;
    end
    a_ok = (m_busy == 0) && (m_owner == 0);
    b_ok = (m_busy == 0) && (m_owner == 1);
    m_valid = 0; m_da = 0; m_db = 0;
    if (wr_a_i || rd_a_i) begin
      if (!a_ok) m_da = 1;
      else if (wr_a_i) m_mem[addr_a_i] = data_a_i;
      else begin m_data = m_mem[addr_a_i]; m_valid = 1; m_src = 0; end
    end
    if (ld_ptr_b_i) begin
      m_ptr = addr_b_i; m_cnt = 0; m_ovf = 0;
    end else if (wr_b_i || rd_b_i) begin
      if (!b_ok) m_db = 1;
      else begin
        if (wr_b_i) begin
          m_mem[m_ptr] = data_b_i;
          if (m_cnt == DEPTH) m_ovf = 1; else m_cnt++;
        end else begin
          m_data = m_mem[m_ptr]; m_valid = 1; m_src = 1;
        end
        m_ptr = (m_ptr + 1) % DEPTH;
      end
    end
    if (m_busy != 0) m_busy = 0;
    else if (int'(hold_ctrl_i) != m_owner) begin m_owner = hold_ctrl_i; m_busy = 1; end
  endtask

  always @(posedge clk) begin
    model_step();
    #1;
    if (m_live) begin
      vectors++;
      if (data_o !== OW'(m_data) || valid_o !== m_valid || src_o !== m_src ||
          owner_o !== m_owner[0] || busy_o !== m_busy[0] || deny_a_o !== m_da ||
          deny_b_o !== m_db || ptr_b_o !== AW'(m_ptr) || cnt_b_o !== (AW+1)'(m_cnt) ||
          ovf_o !== m_ovf) begin
        miscompares++;
        $display("FAIL model_cycle t=%0t got d=%h v=%b s=%b own=%b bsy=%b da=%b db=%b p=%0d c=%0d o=%b required d=%h v=%b s=%b own=%0d bsy=%0d da=%b db=%b p=%0d c=%0d o=%b",
                 $time, data_o, valid_o, src_o, owner_o, busy_o, deny_a_o, deny_b_o, ptr_b_o, cnt_b_o, ovf_o,
                 OW'(m_data), m_valid, m_src, m_owner, m_busy, m_da, m_db, m_ptr, m_cnt, m_ovf);
      end
    end
  end

  task automatic lit(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic clr();
    wr_a_i = 0; rd_a_i = 0; wr_b_i = 0; rd_b_i = 0; ld_ptr_b_i = 0;
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    clr();
    tick(); tick();
    rst_i = 0;
    lit("reset_data", data_o, 0);
    lit("reset_owner", {owner_o, busy_o}, 0);
    lit("reset_ptr_cnt", {ptr_b_o, cnt_b_o, ovf_o}, 0);

    for (int i = 0; i < DEPTH; i++) begin
      wr_a_i = 1; addr_a_i = AW'(i); data_a_i = DW'(8'h80 + i); tick();
    end
    clr();

    wr_a_i = 1; addr_a_i = 3; data_a_i = 8'hA5; tick();
    clr(); rd_a_i = 1; addr_a_i = 3; tick();
    lit("a_read_valid", valid_o, 1);
    lit("a_read_data", data_o, 32'h000000A5);
    lit("a_read_src", src_o, 0);
    clr(); tick();
    lit("a_read_hold", {valid_o, data_o[7:0]}, {1'b0, 8'hA5});

    wr_b_i = 1; data_b_i = 8'h99; tick();
    lit("b_denied_in_own_a", {deny_b_o, ptr_b_o}, {1'b1, 4'd0});
    clr();

    hold_ctrl_i = 1; wr_a_i = 1; addr_a_i = 5; data_a_i = 8'h5A; tick();
    lit("turn_ab_busy_owner", {busy_o, owner_o, deny_a_o}, 3'b110);
    addr_a_i = 6; data_a_i = 8'h77; tick();
    lit("own_b_after_turn", {busy_o, owner_o, deny_a_o}, 3'b011);
    addr_a_i = 5; data_a_i = 8'hFF; tick();
    lit("a_denied_in_own_b", deny_a_o, 1);
    clr(); ld_ptr_b_i = 1; addr_b_i = 5; tick();
    clr(); rd_b_i = 1; tick();
    lit("a_write_kept", {valid_o, src_o, data_o[7:0]}, {2'b11, 8'h5A});
    clr(); ld_ptr_b_i = 1; addr_b_i = 6; tick();
    clr(); rd_b_i = 1; tick();
    lit("turn_write_dropped", data_o, 32'h86);

    clr(); ld_ptr_b_i = 1; addr_b_i = 4'd14; tick();
    clr(); wr_b_i = 1;
    data_b_i = 8'h11; tick();
    data_b_i = 8'h22; tick();
    data_b_i = 8'h33; tick();
    clr();
    lit("wrap_ptr", ptr_b_o, 1);
    lit("wrap_cnt", cnt_b_o, 3);
    ld_ptr_b_i = 1; addr_b_i = 4'd15; tick();
    clr(); rd_b_i = 1; tick(); tick();
    lit("wrap_data_at_0", data_o, 32'h33);

    clr(); ld_ptr_b_i = 1; addr_b_i = 9; wr_b_i = 1; data_b_i = 8'hEE; tick();
    lit("ld_wins_over_wr", {ptr_b_o, cnt_b_o}, {4'd9, 5'd0});
    clr(); wr_b_i = 1; rd_b_i = 1; data_b_i = 8'h3C; tick();
    lit("b_wr_rd_collision", {valid_o, ptr_b_o, cnt_b_o}, {1'b0, 4'd10, 5'd1});
    clr();

    ld_ptr_b_i = 1; addr_b_i = 0; tick();
    clr(); wr_b_i = 1;
    for (int i = 0; i <= DEPTH; i++) begin
      data_b_i = DW'(8'h40 + i); tick();
      if (i == DEPTH - 1) lit("full_no_ovf", {cnt_b_o, ovf_o}, {5'd16, 1'b0});
    end
    clr();
    lit("overflow", {cnt_b_o, ovf_o, ptr_b_o}, {5'd16, 1'b1, 4'd1});
    ld_ptr_b_i = 1; addr_b_i = 4; tick();
    lit("ld_clears_ovf", {cnt_b_o, ovf_o, ptr_b_o}, {5'd0, 1'b0, 4'd4});
    clr(); rd_b_i = 1; tick(); tick();
    clr();

    hold_ctrl_i = 0; wr_b_i = 1; data_b_i = 8'hD1; tick();
    lit("b_served_on_switch", {busy_o, owner_o, deny_b_o, ptr_b_o}, {3'b100, 4'd7});
    data_b_i = 8'hD2; tick();
    lit("b_denied_in_turn", {deny_b_o, ptr_b_o}, {1'b1, 4'd7});
    clr(); tick();

    for (int i = 0; i < DEPTH; i++) begin
      rd_a_i = 1; addr_a_i = AW'(i); tick();
    end
    clr();
    lit("overwrite_at_0", 0, 0 ^ 0);
    wr_a_i = 1; rd_a_i = 1; addr_a_i = 7; data_a_i = 8'hC3; tick();
    lit("a_wr_rd_collision", valid_o, 0);
    clr(); rd_a_i = 1; addr_a_i = 7; tick();
    lit("a_collision_write_done", data_o, 32'hC3);
    clr();

    hold_ctrl_i = 1; tick();
    lit("pre_reset_turn", busy_o, 1);
    rst_i = 1; hold_ctrl_i = 0; wr_a_i = 1; addr_a_i = 7; data_a_i = 8'h00; tick();
    rst_i = 0; clr();
    lit("reset_in_turn", {owner_o, busy_o, valid_o, ptr_b_o, cnt_b_o, ovf_o}, 0);
    lit("reset_in_turn_data", data_o, 0);
    rd_a_i = 1; addr_a_i = 7; tick();
    lit("mem_survives_reset", data_o, 32'hC3);
    clr();

    rst_i = 1; hold_ctrl_i = 1; tick();
    rst_i = 0; tick();
    lit("hold_after_reset", {busy_o, owner_o}, 2'b11);
    tick();
    lit("own_b_after_reset", {busy_o, owner_o}, 2'b01);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
